exhaustive_vector_gen: RTL

- Parametrised, self-checking exhaustive stimulus engine for combinational gate blocks (Not/And/Or/Mux/DMux and wider successors).
- Drives every 2^IN_W input combination onto a DUT and holds each for HOLD cycles.
- Compares DUT output against a golden-model output on the last hold cycle, and accumulates a mismatch count plus the first failing vector.
- Sits in the bench beside the DUT and golden model, replacing hand-written delay-driven stimulus.

---
 rtl/n2t_stim_pkg.sv | 17 +
 rtl/vec_hold_counter.sv | 66 ++++++
 rtl/exhaustive_vector_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/n2t_stim_pkg.sv
// Shared types and helpers for the exhaustive vector generator.
// State encoding, error-counter width and binary-to-Gray conversion.
package n2t_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 16;

  function automatic logic [15:0] bin2gray(input logic [15:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

endpackage

// File: rtl/vec_hold_counter.sv
// Hold-cycle and vector-index counters for the exhaustive vector generator.
// Exposes the next index so the stimulus register can load in step with it.
module vec_hold_counter #(
  parameter int IN_W = 3,
  parameter int HOLD = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_en,
  output logic [IN_W-1:0] o_index_next,
  output logic            o_index_last,
  output logic            o_hold_last,
  output logic            o_next_hold_last
);

  localparam int              HC_W     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD - 1);
  localparam logic [IN_W:0]   LAST_IDX = {1'b0, {IN_W{1'b1}}};

  logic [HC_W-1:0] r_hold;
  logic [HC_W-1:0] w_hold_next;
  logic [IN_W:0]   r_index;
  logic [IN_W:0]   w_index_next;

  assign o_index_last     = (r_index == LAST_IDX);
  assign o_hold_last      = (r_hold == HOLD_MAX);
  assign o_next_hold_last = (w_hold_next == HOLD_MAX);
  assign o_index_next     = w_index_next[IN_W-1:0];

  // Next-state for hold/index; the index freezes on the last vector.
  always_comb begin
    w_hold_next  = r_hold;
    w_index_next = r_index;
    if (i_clr) begin
      w_hold_next  = '0;
      w_index_next = '0;
    end else if (i_en) begin
      if (o_hold_last) begin
        w_hold_next = '0;
        if (!o_index_last) begin
          w_index_next = r_index + (IN_W+1)'(1);
        end else begin
          w_index_next = r_index;
        end
      end else begin
        w_hold_next  = r_hold + HC_W'(1);
        w_index_next = r_index;
      end
    end else begin
      w_hold_next  = r_hold;
      w_index_next = r_index;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold  <= '0;
      r_index <= '0;
    end else begin
      r_hold  <= w_hold_next;
      r_index <= w_index_next;
    end
  end

endmodule

// File: rtl/exhaustive_vector_gen.sv
// Exhaustive stimulus engine: walks all 2^IN_W vectors, compares DUT vs golden.
// Build option GRAY_ORDER_EN switches the vector order to reflected Gray code.
module exhaustive_vector_gen
  import n2t_stim_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2,
  parameter int HOLD  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [IN_W-1:0]      stim,
  input  logic [OUT_W-1:0]     dut_out,
  input  logic [OUT_W-1:0]     exp_out,
  output logic                 check,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_valid,
  output logic [IN_W-1:0]      first_err_vec
);

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  state_t               r_state;
  logic [IN_W-1:0]      r_stim;
  logic                 r_check;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 r_fe_valid;
  logic [IN_W-1:0]      r_fe_vec;

  logic                 w_clr;
  logic                 w_en;
  logic [IN_W-1:0]      w_index_next;
  logic                 w_index_last;
  logic                 w_hold_last;
  logic                 w_next_hold_last;
  logic [IN_W-1:0]      w_stim_next;
  logic                 w_mismatch;
  logic                 w_err_inc;
  logic [ERR_CNT_W-1:0] w_err_after;

  // Reset asserts asynchronously but is released two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_clr = (r_state != APPLY) && start;
  assign w_en  = (r_state == APPLY);

  vec_hold_counter #(
    .IN_W (IN_W),
    .HOLD (HOLD)
  ) u_cnt (
    .clk              (clk),
    .rst_n            (w_rst_n),
    .i_clr            (w_clr),
    .i_en             (w_en),
    .o_index_next     (w_index_next),
    .o_index_last     (w_index_last),
    .o_hold_last      (w_hold_last),
    .o_next_hold_last (w_next_hold_last)
  );

`ifdef GRAY_ORDER_EN
  assign w_stim_next = IN_W'(bin2gray(16'(w_index_next)));
`else
  assign w_stim_next = w_index_next;
`endif

  assign w_mismatch  = (dut_out != exp_out);
  assign w_err_inc   = r_check && w_mismatch && (r_err_count != 16'hFFFF);
  assign w_err_after = r_err_count + ERR_CNT_W'(w_err_inc);

  // Run-control FSM with the compare/capture datapath and registered outputs.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= IDLE;
      r_stim      <= '0;
      r_check     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fe_valid  <= 1'b0;
      r_fe_vec    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state     <= APPLY;
            r_stim      <= w_stim_next;
            r_check     <= w_next_hold_last;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fe_valid  <= 1'b0;
            r_fe_vec    <= '0;
          end
        end
        APPLY: begin
          r_stim      <= w_stim_next;
          r_err_count <= w_err_after;
          if (r_check && w_mismatch && !r_fe_valid) begin
            r_fe_valid <= 1'b1;
            r_fe_vec   <= r_stim;
          end
          // w_hold_last is implied by r_check; the final check ends the run.
          if (r_check && w_hold_last && w_index_last) begin
            r_state <= DONE;
            r_check <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_after == '0);
          end else begin
            r_check <= w_next_hold_last;
          end
        end
        default: begin
          r_state <= IDLE;
          r_check <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign stim            = r_stim;
  assign check           = r_check;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_err_valid = r_fe_valid;
  assign first_err_vec   = r_fe_vec;

endmodule
